branch_update_queue: RTL and testbench

// Writer side of the branch-history cache update port. Records each fetched

---
 rtl/branch_update_queue.sv | 124 ++++++++++++
 tb/tb_branch_update_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_queue.sv
// In-order queue pairing fetched branch predictions with their execute-stage resolutions and
// issuing one history-cache write per resolved branch; mispredicts and pc mismatches flush it.
module branch_update_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = 10,
  parameter int unsigned HIST_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  input  logic [PC_W-1:0]          fetch_pc,
  input  logic                     fetch_pred,
  output logic                     fetch_ready,
  input  logic                     resolve_valid,
  input  logic [PC_W-1:0]          resolve_pc,
  input  logic                     resolve_taken,
  input  logic                     evict,
  output logic                     we,
  output logic [PC_W-1:0]          update_pc,
  output logic                     branch_taken,
  output logic                     mispredict,
  output logic                     sync_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               evict_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  // Elaboration-time sanity checks on the parameter set.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (HIST_W == 0)) begin : g_param_check
    $error("branch_update_queue: DEPTH must be a power of 2 >= 2 and HIST_W > 0");
  end

  typedef enum logic [0:0] {StRun, StRecover} state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q   [DEPTH];
  logic                pred_q [DEPTH];
  logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                we_q, mispredict_q, sync_err_q, branch_taken_q;
  logic [PC_W-1:0]     update_pc_q;
  logic [7:0]          evict_cnt_q;

  logic accept, nonempty, pc_match, hit, mis, pc_err, empty_err, flush, push;

  always_comb begin
    fetch_ready = (state_q == StRun) && (count_q < DepthCnt);
    accept      = resolve_valid && (state_q == StRun);
    nonempty    = (count_q != '0);
    pc_match    = (resolve_pc == pc_q[head_q]);
    hit         = accept && nonempty && pc_match;
    mis         = hit && (resolve_taken != pred_q[head_q]);
    pc_err      = accept && nonempty && !pc_match;
    empty_err   = accept && !nonempty;
    flush       = mis || pc_err;
    push        = fetch_valid && fetch_ready && !flush;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    if (flush) begin
      // Everything younger than the resolved branch is wrong-path: drop it all.
      head_d  = tail_q;
      count_d = '0;
      state_d = StRecover;
    end else begin
      if (hit) head_d = head_q + PtrW'(1);
      if (push) tail_d = tail_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(hit);
      if (state_q == StRecover) state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      we_q           <= 1'b0;
      mispredict_q   <= 1'b0;
      sync_err_q     <= 1'b0;
      branch_taken_q <= 1'b0;
      update_pc_q    <= '0;
      evict_cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        pred_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      we_q         <= hit;
      mispredict_q <= mis;
      sync_err_q   <= pc_err || empty_err;
      if (hit) begin
        update_pc_q    <= pc_q[head_q];
        branch_taken_q <= resolve_taken;
      end
      if (push) begin
        pc_q[tail_q]   <= fetch_pc;
        pred_q[tail_q] <= fetch_pred;
      end
      if (evict && (evict_cnt_q != 8'hFF)) evict_cnt_q <= evict_cnt_q + 8'd1;
    end
  end

  assign we           = we_q;
  assign update_pc    = update_pc_q;
  assign branch_taken = branch_taken_q;
  assign mispredict   = mispredict_q;
  assign sync_err     = sync_err_q;
  assign count        = count_q;
  assign evict_cnt    = evict_cnt_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed-vector bench for branch_update_queue with hand-computed expectations.
module tb_branch_update_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            fetch_valid, fetch_pred, fetch_ready;
  logic [PC_W-1:0] fetch_pc, resolve_pc, update_pc;
  logic            resolve_valid, resolve_taken, evict;
  logic            we, branch_taken, mispredict, sync_err;
  logic [2:0]      count;
  logic [7:0]      evict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  branch_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .HIST_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc),
    .fetch_pred   (fetch_pred),
    .fetch_ready  (fetch_ready),
    .resolve_valid(resolve_valid),
    .resolve_pc   (resolve_pc),
    .resolve_taken(resolve_taken),
    .evict        (evict),
    .we           (we),
    .update_pc    (update_pc),
    .branch_taken (branch_taken),
    .mispredict   (mispredict),
    .sync_err     (sync_err),
    .count        (count),
    .evict_cnt    (evict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_valid   = 1'b0;
    fetch_pc      = '0;
    fetch_pred    = 1'b0;
    resolve_valid = 1'b0;
    resolve_pc    = '0;
    resolve_taken = 1'b0;
  endtask

  task automatic push(input logic [PC_W-1:0] pc, input logic pred);
    idle_inputs();
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_pred  = pred;
    tick();
    idle_inputs();
  endtask

  task automatic resolve(input logic [PC_W-1:0] pc, input logic taken);
    idle_inputs();
    resolve_valid = 1'b1;
    resolve_pc    = pc;
    resolve_taken = taken;
    tick();
    idle_inputs();
  endtask

  initial begin
    rst   = 1'b1;
    evict = 1'b0;
    idle_inputs();
    tick();
    tick();
    check("rst_we", we, 0);
    check("rst_count", count, 0);
    check("rst_ready", fetch_ready, 1);
    check("rst_evict", evict_cnt, 0);
    check("rst_upc", update_pc, 0);
    check("rst_mis", mispredict, 0);
    check("rst_serr", sync_err, 0);
    rst = 1'b0;

    // Single correct prediction.
    push(10'h004, 1'b1);
    check("t1_count_push", count, 1);
    resolve(10'h004, 1'b1);
    check("t1_we", we, 1);
    check("t1_upc", update_pc, 10'h004);
    check("t1_bt", branch_taken, 1);
    check("t1_mis", mispredict, 0);
    check("t1_count", count, 0);
    tick();
    check("t1_we_pulse", we, 0);
    check("t1_upc_hold", update_pc, 10'h004);

    // Mispredict flushes younger entries and drops a same-cycle push.
    push(10'h004, 1'b1);
    push(10'h008, 1'b0);
    push(10'h00C, 1'b0);
    check("t2_count3", count, 3);
    resolve_valid = 1'b1; resolve_pc = 10'h004; resolve_taken = 1'b0;
    fetch_valid   = 1'b1; fetch_pc   = 10'h030; fetch_pred    = 1'b0;
    tick();
    idle_inputs();
    check("t2_we", we, 1);
    check("t2_bt", branch_taken, 0);
    check("t2_mis", mispredict, 1);
    check("t2_count", count, 0);
    check("t2_ready_recover", fetch_ready, 0);
    tick();
    check("t2_ready_back", fetch_ready, 1);
    check("t2_mis_pulse", mispredict, 0);
    check("t2_count_after", count, 0);

    // Fill to DEPTH; push while full is refused even alongside a pop.
    push(10'h040, 1'b0);
    push(10'h044, 1'b0);
    push(10'h048, 1'b0);
    push(10'h04C, 1'b0);
    check("t3_full_count", count, 4);
    check("t3_full_ready", fetch_ready, 0);
    push(10'h050, 1'b1);
    check("t3_no_store", count, 4);
    resolve_valid = 1'b1; resolve_pc = 10'h040; resolve_taken = 1'b0;
    fetch_valid   = 1'b1; fetch_pc   = 10'h050; fetch_pred    = 1'b1;
    tick();
    idle_inputs();
    check("t3_pop_count", count, 3);
    check("t3_pop_upc", update_pc, 10'h040);
    check("t3_ready_again", fetch_ready, 1);
    resolve(10'h044, 1'b0);
    check("t3_pop2_upc", update_pc, 10'h044);
    check("t3_count2", count, 2);

    // Simultaneous push and correct pop; tail wraps past index 3.
    resolve_valid = 1'b1; resolve_pc = 10'h048; resolve_taken = 1'b0;
    fetch_valid   = 1'b1; fetch_pc   = 10'h010; fetch_pred    = 1'b1;
    tick();
    idle_inputs();
    check("t4_count_same", count, 2);
    check("t4_upc", update_pc, 10'h048);
    check("t4_we", we, 1);
    resolve(10'h04C, 1'b0);
    check("t4_upc2", update_pc, 10'h04C);
    check("t4_count1", count, 1);
    resolve(10'h010, 1'b1);
    check("t4_upc3", update_pc, 10'h010);
    check("t4_bt3", branch_taken, 1);
    check("t4_mis3", mispredict, 0);
    check("t4_count0", count, 0);

    // Resolve on empty: sync_err only, no flush, stays in RUN.
    resolve(10'h020, 1'b1);
    check("t5_empty_serr", sync_err, 1);
    check("t5_empty_we", we, 0);
    check("t5_empty_ready", fetch_ready, 1);
    check("t5_empty_upc_hold", update_pc, 10'h010);
    tick();
    check("t5_serr_pulse", sync_err, 0);
    // PC mismatch flushes and enters RECOVER, where resolves are ignored.
    push(10'h004, 1'b1);
    resolve(10'h020, 1'b1);
    check("t5_pc_serr", sync_err, 1);
    check("t5_pc_we", we, 0);
    check("t5_pc_count", count, 0);
    check("t5_pc_ready", fetch_ready, 0);
    resolve(10'h020, 1'b1);
    check("t5_recover_ignored", sync_err, 0);
    check("t5_recover_ready", fetch_ready, 1);

    // Eviction counter saturates.
    evict = 1'b1;
    repeat (254) tick();
    check("t6_evict254", evict_cnt, 254);
    repeat (6) tick();
    check("t6_evict_sat", evict_cnt, 255);
    evict = 1'b0;

    // Reset mid-stream cancels an in-flight write and clears everything.
    push(10'h060, 1'b1);
    check("t7_count1", count, 1);
    resolve_valid = 1'b1; resolve_pc = 10'h060; resolve_taken = 1'b0;
    rst = 1'b1;
    tick();
    idle_inputs();
    check("t7_we", we, 0);
    check("t7_mis", mispredict, 0);
    check("t7_count", count, 0);
    check("t7_evict", evict_cnt, 0);
    check("t7_upc", update_pc, 0);
    check("t7_bt", branch_taken, 0);
    rst = 1'b0;
    tick();
    check("t7_ready", fetch_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
